// File: rtl/fifo_config_controller.sv
// Sequencer and flow-control front end for a depth-configurable FIFO.
// It runs the clear/save/wait handshake that reconfigures the FIFO depth,
// then gates writes and reads against the configured capacity. Each pop is
// followed by one recovery cycle while the FIFO presents its read word.
module fifo_config_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int UNIT_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  cfg_req,
  input  logic [2:0]                            cfg_depth,
  input  logic                                  cfg_flush,
  output logic                                  cfg_busy,
  output logic                                  cfg_done,
  output logic                                  cfg_error,
  input  logic                                  wr_valid,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  output logic                                  wr_ready,
  input  logic                                  rd_req,
  output logic                                  rd_ready,
  output logic                                  rd_valid,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic [$clog2(4*UNIT_DEPTH+1)-1:0]     count,
  output logic                                  fifo_push,
  output logic                                  fifo_pop,
  output logic                                  fifo_reset_data,
  output logic                                  fifo_reset_config,
  output logic                                  fifo_save_config,
  output logic [DATA_WIDTH-1:0]                 fifo_data_in,
  output logic [2:0]                            fifo_configuration,
  input  logic [DATA_WIDTH-1:0]                 fifo_data_out,
  input  logic                                  fifo_buffer_full,
  input  logic                                  fifo_no_config
);

  localparam int CNT_W = $clog2(4*UNIT_DEPTH+1);

  typedef enum logic [2:0] {
    ST_UNCONF,
    ST_CLEAR,
    ST_SAVE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       depth_q, depth_d;
  logic [1:0]       wait_q, wait_d;
  logic             done_d, error_d;
  logic             pop_recov_q;
  logic             depth_ok;
  logic             rd_accept, wr_accept;
  logic [CNT_W-1:0] capacity;

  assign depth_ok = (cfg_depth >= 3'd1) && (cfg_depth <= 3'd4);
  assign capacity = CNT_W'(depth_q) * CNT_W'(UNIT_DEPTH);

  // State, latched depth, WAIT timer and registered status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_UNCONF;
      depth_q   <= '0;
      wait_q    <= '0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      wait_q    <= wait_d;
      cfg_done  <= done_d;
      cfg_error <= error_d;
    end
  end

  // Next-state: request validation, reconfiguration handshake, WAIT timeout
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_UNCONF: begin
        if (cfg_req) begin
          if (depth_ok) begin
            state_d = ST_CLEAR;
            depth_d = cfg_depth;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_CLEAR: state_d = ST_SAVE;
      ST_SAVE: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (!fifo_no_config) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else if (wait_q == 2'd3) begin
          state_d = ST_UNCONF;
          error_d = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_RUN: begin
        // Reconfiguring a non-empty FIFO is only allowed when the caller
        // agrees to discard its contents.
        if (cfg_req) begin
          if (depth_ok && ((count == '0) || cfg_flush)) begin
            state_d = ST_CLEAR;
            depth_d = cfg_depth;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_UNCONF;
    endcase
  end

  // Outputs: handshake readiness and FIFO control strobes
  always_comb begin
    cfg_busy           = (state_q == ST_CLEAR) || (state_q == ST_SAVE) ||
                         (state_q == ST_WAIT);
    rd_ready           = (state_q == ST_RUN) && (count != '0) &&
                         !pop_recov_q && !cfg_req;
    rd_accept          = rd_req && rd_ready;
    // Reads win over writes so push and pop never coincide.
    wr_ready           = (state_q == ST_RUN) && (count < capacity) &&
                         !fifo_buffer_full && !pop_recov_q && !cfg_req &&
                         !rd_accept;
    wr_accept          = wr_valid && wr_ready;
    fifo_push          = wr_accept;
    fifo_pop           = rd_accept;
    fifo_reset_data    = !reset_n || (state_q == ST_CLEAR);
    fifo_reset_config  = !reset_n || (state_q == ST_CLEAR);
    fifo_save_config   = (state_q == ST_SAVE);
    fifo_configuration = depth_q;
    fifo_data_in       = wr_data;
  end

  // Occupancy counter and two-stage read return (recovery, then valid)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      pop_recov_q <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (state_q == ST_CLEAR) begin
        count <= '0;
      end else if (wr_accept) begin
        count <= count + CNT_W'(1);
      end else if (rd_accept) begin
        count <= count - CNT_W'(1);
      end
      pop_recov_q <= rd_accept;
      rd_valid    <= pop_recov_q;
      if (pop_recov_q) begin
        rd_data <= fifo_data_out;
      end
    end
  end

endmodule

// File: doc/fifo_config_controller.md
FIFO_CONFIG_CONTROLLER -- requirements
Module: fifo_config_controller

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 8, data word width.
- UNIT_DEPTH, 4, entries per sub-buffer unit; UNIT_DEPTH >= 1.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all flops rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_req  in  1  one-cycle request to (re)configure depth.
- cfg_depth  in  3  requested sub-buffer count, 1..4; sampled with cfg_req.
- cfg_flush  in  1  sampled with cfg_req; 1 = discard stored data.
- cfg_busy  out  1  reconfiguration sequence in progress.
- cfg_done  out  1  one-cycle pulse on sequence success.
- cfg_error  out  1  one-cycle pulse on rejected request or timeout.
- wr_valid  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- rd_req  in  1  read request.
- rd_ready  out  1  read accepted when rd_req & rd_ready.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  DATA_WIDTH  registered read word.
- count  out  clog2(4*UNIT_DEPTH+1)  stored entries.
- fifo_push, fifo_pop, fifo_reset_data, fifo_reset_config, fifo_save_config  out  1 each  drive the configurable FIFO.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- fifo_configuration  out  3  FIFO depth code.
- fifo_data_out  in  DATA_WIDTH  FIFO read data.
- fifo_buffer_full, fifo_no_config  in  1 each  FIFO status.

Function
REQ-003 Main FSM states SHALL be UNCONF, CLEAR, SAVE, WAIT, RUN.
REQ-004 UNCONF SHALL hold until cfg_req. A valid depth (1..4) SHALL go to CLEAR. An invalid depth SHALL pulse cfg_error and stay in UNCONF.
REQ-005 CLEAR SHALL last 1 cycle and assert fifo_reset_config=1 and fifo_reset_data=1; count SHALL become 0.
REQ-006 SAVE SHALL last 1 cycle with fifo_save_config=1 and fifo_configuration=latched depth; fifo_configuration SHALL hold the latched depth in all later states.
REQ-007 WAIT SHALL exit to RUN with a cfg_done pulse on the first cycle fifo_no_config=0. If fifo_no_config is still 1 after 4 WAIT cycles, it SHALL pulse cfg_error and go to UNCONF.
REQ-008 cfg_busy SHALL be 1 in CLEAR, SAVE and WAIT; otherwise 0.
REQ-009 cfg_req in RUN:
- count=0 or cfg_flush=1: go to CLEAR.
- Otherwise: pulse cfg_error and stay in RUN.
- Invalid depth: cfg_error in every case.
- Any accepted cfg_req SHALL block read/write acceptance in that same cycle.
REQ-010 capacity SHALL be latched depth * UNIT_DEPTH.
REQ-011 rd_ready SHALL be 1 only in RUN with count>0, no pop recovery, and no cfg_req.
REQ-012 wr_ready SHALL be 1 only in RUN with count<capacity, fifo_buffer_full=0, no pop recovery, no cfg_req, and no rd_req & rd_ready in the same cycle. Read has priority; there is no simultaneous push and pop.
REQ-013 An accepted write SHALL drive fifo_push=1 and fifo_data_in=wr_data combinationally in the same cycle; count SHALL increment.
REQ-014 An accepted read SHALL drive fifo_pop=1 for 1 cycle; count SHALL decrement. The next cycle SHALL be the recovery cycle: no push, no pop.
REQ-015 In the recovery cycle, rd_data SHALL register fifo_data_out; rd_valid SHALL pulse in the cycle after it, i.e. 2 cycles after acceptance.
REQ-016 The fastest read rate SHALL be one read per 2 cycles.
REQ-017 count SHALL never wrap below 0 or exceed capacity.
REQ-018 All fifo_* controls SHALL be 0 except as stated, apart from fifo_configuration and fifo_data_in.

Reset
REQ-019 reset_n=0 SHALL asynchronously force:
- state UNCONF, count 0, rd_data 0, latched depth 0.
- all pulse and ready outputs 0.
- fifo_reset_config=1 and fifo_reset_data=1 while reset_n=0.
REQ-020 Reset mid-sequence or mid-read SHALL abandon the operation; no rd_valid, cfg_done or cfg_error SHALL follow.

Verification
REQ-021 Reset, then cfg_req with depth 2: CLEAR, SAVE, then cfg_done 1 cycle after no_config falls; capacity 8 with UNIT_DEPTH=4.
REQ-022 Write 0x11..0x18 at depth 2: count=8, wr_ready=0; a 9th wr_valid is not pushed.
REQ-023 rd_req held high with count=3: fifo_pop every 2nd cycle; rd_valid data 0x11, 0x12, 0x13; then rd_ready=0.
REQ-024 rd_req and wr_valid together: pop issued, push stalled 2 cycles, count unchanged net after the later write.
REQ-025 cfg_req depth 4 with count=2 and cfg_flush=0: cfg_error, data retained. With cfg_flush=1: count=0 and cfg_done.
REQ-026 cfg_depth=5: cfg_error. no_config held at 1 in WAIT: cfg_error after 4 cycles, back to UNCONF. reset_n low during WAIT: no pulses.
